serial_adder: RTL and testbench
===============================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand width in bits; legal range 2..64.
REQ-002 SHALL have parameter CHUNK, default 2: bits added per cycle; 1..WIDTH, WIDTH divisible by CHUNK.
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port a, input, WIDTH: operand A, sampled at input handshake.
REQ-006 SHALL have port b, input, WIDTH: operand B, sampled at input handshake.
REQ-007 SHALL have port cin, input, 1: carry-in, sampled at input handshake.
REQ-008 SHALL have port in_valid, input, 1: operands valid.
REQ-009 SHALL have port in_ready, output, 1: block can accept operands.
REQ-010 SHALL have port sum, output, WIDTH: result bits.
REQ-011 SHALL have port carry, output, 1: carry-out of MSB.
REQ-012 SHALL have port out_valid, output, 1: sum/carry valid.
REQ-013 SHALL have port out_ready, input, 1: consumer accepts result.

Function
REQ-014 SHALL implement FSM states IDLE, ADD, DONE; one-hot or encoded is implementation choice.
REQ-015 SHALL assert in_ready only in IDLE; input handshake = in_valid && in_ready.
REQ-016 On input handshake SHALL capture a, b, cin into internal registers, clear chunk counter, go IDLE->ADD.
REQ-017 In ADD SHALL each cycle add the next CHUNK-bit slice (LSB first) plus running carry, storing the slice of sum and updating carry.
REQ-018 SHALL leave ADD for DONE after exactly WIDTH/CHUNK ADD cycles; counter wrap SHALL NOT occur.
REQ-019 Latency: out_valid SHALL rise WIDTH/CHUNK+1 cycles after the input-handshake edge (CHUNK=WIDTH: 2 cycles).
REQ-020 In DONE SHALL hold out_valid=1 and sum/carry stable until out_ready=1.
REQ-021 Output handshake (out_valid && out_ready) SHALL return DONE->IDLE; in_ready rises the next cycle; no back-to-back acceptance in the same cycle.
REQ-022 {carry,sum} SHALL equal a+b+cin modulo 2^(WIDTH+1), unsigned.
REQ-023 Changes on a, b, cin, in_valid outside IDLE SHALL have no effect on the result in flight.
REQ-024 sum/carry SHALL hold last completed result in IDLE and ADD states (not partial values until DONE is visible is not required; only DONE values are specified).

Reset
REQ-025 reset_n=0 SHALL asynchronously force IDLE, in_ready=1, out_valid=0, sum=0, carry=0, counter=0 (in_ready combinational from state).
REQ-026 Reset asserted during ADD or DONE SHALL abort the operation; no out_valid pulse after release.
REQ-027 After reset_n deasserts, first input handshake SHALL be possible on the first rising edge.

Configuration
REQ-028 Macro SERIAL_ADDER_OVERFLOW_EN defined: SHALL add output port overflow, 1 bit, = signed two's-complement overflow of a+b+cin (carry into MSB XOR carry out), valid with out_valid, reset 0.
REQ-029 Macro undefined: overflow port and its logic SHALL be absent; all other behaviour identical.

Verification
REQ-030 WIDTH=8, CHUNK=2: a=0xFF, b=0x01, cin=0 -> out_valid 5 cycles after handshake, sum=0x00, carry=1 (overflow=0 if enabled).
REQ-031 WIDTH=8, CHUNK=2: a=0x7F, b=0x00, cin=1 -> sum=0x80, carry=0, overflow=1 if enabled.
REQ-032 Back-pressure: hold out_ready=0 for 10 cycles in DONE -> out_valid, sum, carry stable, in_ready=0 throughout; release -> in_ready=1 next cycle.
REQ-033 Assert reset_n=0 mid-ADD -> out_valid=0, sum=0 immediately; no result emitted; next operand pair processed correctly.
REQ-034 Random: 1000 operand triples, random in_valid/out_ready gaps, CHUNK in {1,2,8} -> every result matches a+b+cin reference model; mismatch prints a, b, cin, sum, expected.

Source files
------------

// File: rtl/serial_adder.sv
// serial_adder -- multi-cycle unsigned adder that consumes CHUNK bits per cycle.
//
// Computes {carry, sum} = a + b + cin (mod 2^(WIDTH+1)) by walking the operands
// LSB-first, CHUNK bits per ADD cycle, with a running carry between slices.
//
// Parameters
//   WIDTH : operand width, 2..64
//   CHUNK : bits added per cycle, 1..WIDTH, WIDTH % CHUNK == 0
//
// Ports
//   clk, reset_n        : clock (rising edge), asynchronous active-low reset
//   a, b, cin           : operands, captured on in_valid && in_ready
//   in_valid, in_ready  : input handshake; in_ready is high only in IDLE
//   sum, carry          : registered result, updated only when a new result commits
//   out_valid, out_ready: output handshake; result held until out_ready
//   overflow            : signed two's-complement overflow of a+b+cin
//                         (present only when SERIAL_ADDER_OVERFLOW_EN is defined)
//
// Timing: the handshake edge enters ADD; WIDTH/CHUNK ADD cycles follow, then
// DONE. The first DONE cycle loads the output registers, so out_valid rises
// WIDTH/CHUNK+1 edges after the handshake edge.

module serial_adder_chunk #(
    parameter int CHUNK = 2
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout
);
    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
endmodule

module serial_adder #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             out_valid,
    input  logic             out_ready
`ifdef SERIAL_ADDER_OVERFLOW_EN
   ,output logic             overflow
`endif
);
    localparam int NCH = WIDTH / CHUNK;
    localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [CW-1:0] LAST = CW'(NCH - 1);

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_q, b_q;   // shift right by CHUNK each ADD cycle
    logic [WIDTH-1:0] acc;        // partial sum, filled from the top down
    logic             c_run;      // carry between slices
    logic [CW-1:0]    cnt;

    logic [CHUNK-1:0] slice_sum;
    logic             slice_cout;
    logic [WIDTH-1:0] slice_ext;

    serial_adder_chunk #(.CHUNK(CHUNK)) u_chunk (
        .a    (a_q[CHUNK-1:0]),
        .b    (b_q[CHUNK-1:0]),
        .cin  (c_run),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    assign slice_ext = WIDTH'(slice_sum);
    assign in_ready  = (state == IDLE);

`ifdef SERIAL_ADDER_OVERFLOW_EN
    // Signed overflow (carry into MSB != carry out of MSB) is equivalent to
    // equal operand signs with a result sign that differs from them, which
    // only needs the operand MSBs kept from capture time.
    logic a_msb, b_msb;
    logic ovf_next;
    assign ovf_next = (a_msb == b_msb) && (acc[WIDTH-1] != a_msb);
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            acc       <= '0;
            c_run     <= 1'b0;
            cnt       <= '0;
            sum       <= '0;
            carry     <= 1'b0;
            out_valid <= 1'b0;
`ifdef SERIAL_ADDER_OVERFLOW_EN
            a_msb     <= 1'b0;
            b_msb     <= 1'b0;
            overflow  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q   <= a;
                        b_q   <= b;
                        c_run <= cin;
                        acc   <= '0;
                        cnt   <= '0;
`ifdef SERIAL_ADDER_OVERFLOW_EN
                        a_msb <= a[WIDTH-1];
                        b_msb <= b[WIDTH-1];
`endif
                        state <= ADD;
                    end
                end
                ADD: begin
                    a_q   <= a_q >> CHUNK;
                    b_q   <= b_q >> CHUNK;
                    c_run <= slice_cout;
                    // New slice enters at the top; after NCH cycles the LSB
                    // slice has been shifted down to bit 0.
                    acc   <= (acc >> CHUNK) | (slice_ext << (WIDTH - CHUNK));
                    if (cnt == LAST) begin
                        cnt   <= '0;
                        state <= DONE;
                    end else begin
                        cnt   <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    if (!out_valid) begin
                        sum       <= acc;
                        carry     <= c_run;
                        out_valid <= 1'b1;
`ifdef SERIAL_ADDER_OVERFLOW_EN
                        overflow  <= ovf_next;
`endif
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_adder.sv
// Directed + randomized bench for serial_adder. Three instances (CHUNK = 2, 1, 8,
// WIDTH = 8) share clock and reset; one instance is exercised at a time.
module tb_serial_adder;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] a_s[3], b_s[3], sm[3];
    logic       cin_s[3], iv[3], ir[3], ov[3], ordy[3], car[3];
`ifdef SERIAL_ADDER_OVERFLOW_EN
    logic       ovf[3];
`endif
    logic [8:0] prev[3];
    int         n_chk = 0;
    int         n_err = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8), .CHUNK(2)) u_c2 (
        .clk(clk), .reset_n(rst_n), .a(a_s[0]), .b(b_s[0]), .cin(cin_s[0]),
        .in_valid(iv[0]), .in_ready(ir[0]), .sum(sm[0]), .carry(car[0]),
        .out_valid(ov[0]), .out_ready(ordy[0])
`ifdef SERIAL_ADDER_OVERFLOW_EN
       ,.overflow(ovf[0])
`endif
    );
    serial_adder #(.WIDTH(8), .CHUNK(1)) u_c1 (
        .clk(clk), .reset_n(rst_n), .a(a_s[1]), .b(b_s[1]), .cin(cin_s[1]),
        .in_valid(iv[1]), .in_ready(ir[1]), .sum(sm[1]), .carry(car[1]),
        .out_valid(ov[1]), .out_ready(ordy[1])
`ifdef SERIAL_ADDER_OVERFLOW_EN
       ,.overflow(ovf[1])
`endif
    );
    serial_adder #(.WIDTH(8), .CHUNK(8)) u_c8 (
        .clk(clk), .reset_n(rst_n), .a(a_s[2]), .b(b_s[2]), .cin(cin_s[2]),
        .in_valid(iv[2]), .in_ready(ir[2]), .sum(sm[2]), .carry(car[2]),
        .out_valid(ov[2]), .out_ready(ordy[2])
`ifdef SERIAL_ADDER_OVERFLOW_EN
       ,.overflow(ovf[2])
`endif
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One full transaction on instance k; hold = cycles of back-pressure in DONE.
    task automatic do_op(input int k, input logic [7:0] av, input logic [7:0] bv,
                         input logic cv, input int hold);
        logic [8:0] exp;
        int         cyc;
        int         lat;
        int         s;
        string      id;
        exp = {1'b0, av} + {1'b0, bv} + {8'd0, cv};
        s   = int'($signed(av)) + int'($signed(bv)) + int'(cv);
        lat = (k == 0) ? 5 : (k == 1) ? 9 : 2;
        id  = $sformatf("k%0d a=%02h b=%02h cin=%0d", k, av, bv, cv);
        chk({id, " in_ready_idle"}, 64'(ir[k]), 64'd1);
        a_s[k] = av; b_s[k] = bv; cin_s[k] = cv; iv[k] = 1'b1;
        @(posedge clk); #1;
        // Garbage on the inputs while busy must not disturb the result.
        a_s[k] = ~av; b_s[k] = 8'($urandom); cin_s[k] = ~cv;
        chk({id, " sum_held_add"}, 64'(sm[k]), 64'(prev[k][7:0]));
        chk({id, " carry_held_add"}, 64'(car[k]), 64'(prev[k][8]));
        chk({id, " in_ready_busy"}, 64'(ir[k]), 64'd0);
        cyc = 0;
        while (!ov[k] && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 1) iv[k] = 1'b0;
        end
        chk({id, " latency"}, 64'(cyc), 64'(lat));
        chk({id, " sum"}, 64'(sm[k]), 64'(exp[7:0]));
        chk({id, " carry"}, 64'(car[k]), 64'(exp[8]));
`ifdef SERIAL_ADDER_OVERFLOW_EN
        chk({id, " overflow"}, 64'(ovf[k]), 64'((s > 127) || (s < -128)));
`endif
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk({id, " bp_valid"}, 64'(ov[k]), 64'd1);
            chk({id, " bp_sum"}, 64'({car[k], sm[k]}), 64'(exp));
            chk({id, " bp_in_ready"}, 64'(ir[k]), 64'd0);
        end
        ordy[k] = 1'b1;
        @(posedge clk); #1;
        ordy[k] = 1'b0;
        chk({id, " in_ready_after"}, 64'(ir[k]), 64'd1);
        chk({id, " valid_after"}, 64'(ov[k]), 64'd0);
        chk({id, " sum_held_idle"}, 64'({car[k], sm[k]}), 64'(exp));
        prev[k] = exp;
        if (s == 1000) n_chk = n_chk;  // keeps s referenced when overflow is compiled out
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            a_s[k] = '0; b_s[k] = '0; cin_s[k] = 1'b0; iv[k] = 1'b0; ordy[k] = 1'b0;
            prev[k] = '0;
        end
        // Reset values
        #12;
        chk("rst_in_ready", 64'(ir[0]), 64'd1);
        chk("rst_out_valid", 64'(ov[0]), 64'd0);
        chk("rst_sum", 64'({car[0], sm[0]}), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Directed vectors (hand-computed in comments)
        do_op(0, 8'hFF, 8'h01, 1'b0, 0);   // 0x100: sum 00, carry 1, no ovf
        do_op(0, 8'h7F, 8'h00, 1'b1, 0);   // 0x080: sum 80, carry 0, ovf
        do_op(0, 8'hA5, 8'h5A, 1'b1, 10);  // 0x100 with 10 cycles back-pressure
        do_op(0, 8'h80, 8'h80, 1'b0, 0);   // 0x100: sum 00, carry 1, ovf
        do_op(1, 8'h3C, 8'hC3, 1'b1, 2);   // 0x100
        do_op(2, 8'h12, 8'h34, 1'b1, 1);   // 0x047

        // Reset mid-ADD aborts the operation
        a_s[0] = 8'h55; b_s[0] = 8'h66; cin_s[0] = 1'b0; iv[0] = 1'b1;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", 64'(ov[0]), 64'd0);
        chk("abort_sum", 64'({car[0], sm[0]}), 64'd0);
        chk("abort_in_ready", 64'(ir[0]), 64'd1);
        for (int k = 0; k < 3; k++) prev[k] = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        // First edge after release accepts; latency check catches any stale pulse.
        do_op(0, 8'h12, 8'h34, 1'b0, 0);   // 0x046

        // Random operands with random gaps
        for (int k = 0; k < 3; k++) begin
            for (int n = 0; n < 60; n++) begin
                repeat ($urandom_range(0, 3)) @(posedge clk);
                #1;
                do_op(k, 8'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
